// File: rtl/ltc2174_ser_model_if.sv
// Sample-side and serial-side signals of the LTC2174 serial transmitter model.
// master = sample source / serial sink, slave = the transmitter model itself.
interface ltc2174_ser_model_if #(
    parameter int UNDERRUN_W = 16
);
    logic [13:0]           din0;
    logic [13:0]           din1;
    logic [13:0]           din2;
    logic [13:0]           din3;
    logic                  din_valid;
    logic                  din_ready;
    logic [1:0]            mode;
    logic                  slip;
    logic                  fr;
    logic [3:0]            adca;
    logic [3:0]            adcb;
    logic                  frame_start;
    logic [UNDERRUN_W-1:0] underrun;

    // din_ready is a per-frame load strobe, not a stall: a set is taken on
    // every edge where din_ready=1, using din_valid to pick fresh vs repeat.
    modport master (
        output din0, din1, din2, din3, din_valid, mode, slip,
        input  din_ready, fr, adca, adcb, frame_start, underrun
    );

    modport slave (
        input  din0, din1, din2, din3, din_valid, mode, slip,
        output din_ready, fr, adca, adcb, frame_start, underrun
    );
endinterface

// File: rtl/ltc2174_ser_model.sv
// Bit-level LTC2174 2-lane 14-bit serial transmitter model: four channels plus
// frame clock, 8 bits per frame, with test patterns, slip injection and underrun count.
module ltc2174_ser_model #(
    parameter logic [7:0] FR_PATTERN = 8'hF0,
    parameter int         UNDERRUN_W = 16,
    parameter int         RAMP_STEP  = 1
) (
    input logic               clk,
    input logic               rst,
    ltc2174_ser_model_if.slave bus
);
    localparam logic [13:0] RAMP_INC = 14'(RAMP_STEP);
    localparam logic [UNDERRUN_W-1:0] UND_ONE = {{(UNDERRUN_W-1){1'b0}}, 1'b1};

    logic [2:0]            b_q, b_d;
    logic [3:0][13:0]      frame_q, frame_d;
    logic [3:0][13:0]      hold_q, hold_d;
    logic [13:0]           ramp_q, ramp_d;
    logic                  alt_q, alt_d;
    logic [1:0]            last_mode_q, last_mode_d;
    logic [UNDERRUN_W-1:0] und_q, und_d;
    logic                  fr_q, fr_d;
    logic [3:0]            adca_q, adca_d;
    logic [3:0]            adcb_q, adcb_d;
    logic                  fs_q, fs_d;
    logic                  load;
    logic [13:0]           pat_first, pat_second, pat_val;

    // Lane A carries the odd sample bits, lane B the even ones; bit 7 is a pad 0.
    function automatic logic lane_bit(input logic [13:0] d, input logic [2:0] idx,
                                      input logic lane_b);
        logic [3:0] pos;
        if (idx == 3'd7) return 1'b0;
        pos = 4'd13 - {idx, 1'b0} - {3'b000, lane_b};
        return d[pos];
    endfunction

    always_comb begin
        load        = (b_q == 3'd7) && !bus.slip;
        b_d         = bus.slip ? b_q : b_q + 3'd1;
        frame_d     = frame_q;
        hold_d      = hold_q;
        ramp_d      = ramp_q;
        alt_d       = alt_q;
        last_mode_d = last_mode_q;
        und_d       = und_q;
        pat_first   = (bus.mode == 2'd2) ? 14'h2AAA : 14'h3FFF;
        pat_second  = (bus.mode == 2'd2) ? 14'h1555 : 14'h0000;
        pat_val     = pat_first;

        if (load) begin
            last_mode_d = bus.mode;
            case (bus.mode)
                2'd0: begin
                    if (bus.din_valid) begin
                        frame_d = {bus.din3, bus.din2, bus.din1, bus.din0};
                        hold_d  = {bus.din3, bus.din2, bus.din1, bus.din0};
                    end else begin
                        frame_d = hold_q;
                        if (und_q != {UNDERRUN_W{1'b1}}) und_d = und_q + UND_ONE;
                    end
                end
                2'd1: begin
                    for (int k = 0; k < 4; k++) frame_d[k] = ramp_q + 14'(k);
                    ramp_d = ramp_q + RAMP_INC;
                end
                default: begin
                    // alt_q=1 means the second value is due; a mode change restarts at the first.
                    if ((bus.mode != last_mode_q) || !alt_q) begin
                        pat_val = pat_first;
                        alt_d   = 1'b1;
                    end else begin
                        pat_val = pat_second;
                        alt_d   = 1'b0;
                    end
                    for (int k = 0; k < 4; k++) frame_d[k] = pat_val;
                end
            endcase
        end

        fr_d   = fr_q;
        adca_d = adca_q;
        adcb_d = adcb_q;
        fs_d   = fs_q;
        if (!bus.slip) begin
            fr_d = FR_PATTERN[3'd7 - b_d];
            fs_d = (b_d == 3'd0);
            for (int k = 0; k < 4; k++) begin
                adca_d[k] = lane_bit(frame_d[k], b_d, 1'b0);
                adcb_d[k] = lane_bit(frame_d[k], b_d, 1'b1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q         <= 3'd7;
            frame_q     <= '0;
            hold_q      <= '0;
            ramp_q      <= '0;
            alt_q       <= 1'b0;
            last_mode_q <= 2'd0;
            und_q       <= '0;
            fr_q        <= 1'b0;
            adca_q      <= '0;
            adcb_q      <= '0;
            fs_q        <= 1'b0;
        end else begin
            b_q         <= b_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            ramp_q      <= ramp_d;
            alt_q       <= alt_d;
            last_mode_q <= last_mode_d;
            und_q       <= und_d;
            fr_q        <= fr_d;
            adca_q      <= adca_d;
            adcb_q      <= adcb_d;
            fs_q        <= fs_d;
        end
    end

    assign bus.din_ready   = load;
    assign bus.fr          = fr_q;
    assign bus.adca        = adca_q;
    assign bus.adcb        = adcb_q;
    assign bus.frame_start = fs_q;
    assign bus.underrun    = und_q;
endmodule

// File: tb/tb_ltc2174_ser_model.sv
// Randomised scoreboard bench for ltc2174_ser_model: a frame-level reference model
// queues expected frames, a monitor rebuilds frames from the serial lanes and compares.
module tb_ltc2174_ser_model;
  localparam int UW = 8;
  localparam int RSTEP = 4093;
  localparam logic [7:0] FRP = 8'hF0;
  localparam int EW = 8 + 32 + 32 + UW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ltc2174_ser_model_if #(.UNDERRUN_W(UW)) bus ();
  ltc2174_ser_model #(.FR_PATTERN(FRP), .UNDERRUN_W(UW), .RAMP_STEP(RSTEP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  int mph;
  bit mframe;
  bit rep;
  bit mon_en = 1'b0;
  logic [13:0] m_hold[4];
  int m_ramp, m_und, m_prev_mode, m_alt_cnt;
  logic [13:0] cur_din[4];
  logic [13:0] fix_din[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane_byte(input logic [13:0] d, input int lb);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r[7-i] = d[13-2*i-lb];
    return r;
  endfunction

  task automatic model_reset();
    mph = 7;
    mframe = 1'b0;
    rep = 1'b0;
    for (int k = 0; k < 4; k++) m_hold[k] = '0;
    m_ramp = 0;
    m_und = 0;
    m_prev_mode = -1;
    m_alt_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_load(input bit v, input int m);
    logic [13:0] s[4];
    logic [13:0] val;
    logic [31:0] a, b;
    case (m)
      0: begin
        if (v) begin
          s = cur_din;
          m_hold = cur_din;
        end else begin
          s = m_hold;
          if (m_und < (1 << UW) - 1) m_und++;
        end
      end
      1: begin
        for (int k = 0; k < 4; k++) s[k] = 14'((m_ramp + k) % 16384);
        m_ramp = (m_ramp + RSTEP) % 16384;
      end
      default: begin
        if (m != m_prev_mode) m_alt_cnt = 0;
        if (m == 2) val = (m_alt_cnt % 2 == 0) ? 14'h2AAA : 14'h1555;
        else        val = (m_alt_cnt % 2 == 0) ? 14'h3FFF : 14'h0000;
        m_alt_cnt++;
        for (int k = 0; k < 4; k++) s[k] = val;
      end
    endcase
    m_prev_mode = m;
    for (int k = 0; k < 4; k++) begin
      a[8*k +: 8] = lane_byte(s[k], 0);
      b[8*k +: 8] = lane_byte(s[k], 1);
    end
    exp_q.push_back({FRP, a, b, UW'(m_und)});
  endtask

  // clock/reset: asserted mid-cycle, released just after a rising edge
  task automatic apply_reset();
    @(negedge clk);
    #3;
    bus.slip = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_outputs", {bus.fr, bus.adca, bus.adcb, bus.frame_start}, '0);
    chk("rst_underrun", bus.underrun, '0);
    chk("rst_din_ready", bus.din_ready, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // driver: one bit cycle
  task automatic step(input int m, input bit v, input bit s);
    bit ready_exp;
    @(negedge clk);
    #1;
    bus.din0 = cur_din[0];
    bus.din1 = cur_din[1];
    bus.din2 = cur_din[2];
    bus.din3 = cur_din[3];
    bus.din_valid = v;
    bus.mode = 2'(m);
    bus.slip = s;
    #1;
    ready_exp = (mph == 7) && !s;
    chk("din_ready", bus.din_ready, ready_exp);
    if (ready_exp) model_load(v, m);
    @(posedge clk);
    #1;
    if (ready_exp) mframe = 1'b1;
    rep = s;
    if (!s) mph = (mph + 1) % 8;
  endtask

  task automatic run(input int ncyc, input int m, input int vpct, input int spct, input bit use_fix);
    bit v, s;
    for (int i = 0; i < ncyc; i++) begin
      for (int k = 0; k < 4; k++)
        cur_din[k] = use_fix ? fix_din[k] : 14'($urandom_range(0, 16383));
      v = ($urandom_range(0, 99) < vpct);
      s = ($urandom_range(0, 99) < spct);
      step(m, v, s);
    end
  endtask

  // monitor: rebuild frames from the serial outputs and score them
  initial begin
    logic [7:0] c_fr;
    logic [31:0] c_a, c_b;
    logic [UW-1:0] c_und;
    logic [9:0] outs, prev_out;
    logic [UW-1:0] prev_und;
    logic [EW-1:0] e;
    bit prev_ok;
    prev_ok = 1'b0;
    c_fr = '0; c_a = '0; c_b = '0; c_und = '0;
    prev_out = '0; prev_und = '0;
    forever begin
      @(negedge clk);
      outs = {bus.fr, bus.adca, bus.adcb, bus.frame_start};
      if (!mon_en || rst) begin
        prev_ok = 1'b0;
      end else begin
        if (rep) begin
          if (prev_ok) begin
            chk("slip_repeat", outs, prev_out);
            chk("slip_underrun", bus.underrun, prev_und);
          end
        end else begin
          chk("frame_start", bus.frame_start, (mph == 0));
          if (mframe) begin
            if (mph == 0) c_und = bus.underrun;
            c_fr[7-mph] = bus.fr;
            for (int k = 0; k < 4; k++) begin
              c_a[8*k+7-mph] = bus.adca[k];
              c_b[8*k+7-mph] = bus.adcb[k];
            end
            if (mph == 7) begin
              if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame: no expected entry at %0t", $time);
              end else begin
                e = exp_q.pop_front();
                chk("frame", {c_fr, c_a, c_b, c_und}, e);
              end
            end
          end
        end
        prev_out = outs;
        prev_und = bus.underrun;
        prev_ok = 1'b1;
      end
    end
  end

  initial begin
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0; bus.din3 = '0;
    bus.din_valid = 1'b0; bus.mode = 2'd0; bus.slip = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cur_din[k] = '0;
      fix_din[k] = '0;
    end
    model_reset();
    apply_reset();
    mon_en = 1'b1;

    // full-scale channel 0, then 0x2AAA on channel 1
    fix_din = '{14'h3FFF, 14'h0000, 14'h0000, 14'h0000};
    run(40, 0, 100, 0, 1'b1);
    fix_din = '{14'h3FFF, 14'h2AAA, 14'h1555, 14'h0001};
    run(24, 0, 100, 0, 1'b1);
    run(200, 0, 70, 0, 1'b0);

    // three repeats of 0x1234 without fresh data
    apply_reset();
    fix_din = '{14'h1234, 14'h0ABC, 14'h2001, 14'h3FFE};
    run(8, 0, 100, 0, 1'b1);
    run(24, 0, 0, 0, 1'b1);
    chk("underrun_after_3", bus.underrun, 3);

    // isolated single-cycle slips, then random slips including multi-cycle runs
    for (int j = 0; j < 3; j++) begin
      run(5 + j, 0, 100, 0, 1'b0);
      step(0, 1'b1, 1'b1);
      run(10, 0, 100, 0, 1'b0);
    end
    run(300, 0, 80, 15, 1'b0);

    // ramp from reset, with wrap at 2^14
    apply_reset();
    run(96, 1, 50, 0, 1'b0);
    run(64, 1, 50, 10, 1'b0);

    // alternating patterns and mode switching
    run(40, 2, 50, 0, 1'b0);
    run(40, 3, 50, 5, 1'b0);
    run(16, 2, 50, 0, 1'b0);
    run(16, 0, 100, 0, 1'b0);
    run(24, 2, 50, 0, 1'b0);

    // underrun saturation
    run(270 * 8, 0, 0, 5, 1'b0);
    chk("underrun_saturated", bus.underrun, {UW{1'b1}});

    // reset in the middle of a full-scale frame
    fix_din = '{14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF};
    run(16, 0, 100, 0, 1'b1);
    while (mph != 3) step(0, 1'b1, 1'b0);
    apply_reset();
    run(24, 0, 100, 0, 1'b1);
    run(40, 0, 60, 10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
